jpeg_idct_buf: RTL

- Coefficient block buffer between the dequant/dezigzag stage (upstream) and the IDCT (downstream).
- Collects sparse, out-of-order dequantised coefficients for one 8x8 block, addressed by natural (dezigzagged) index, until EOB.
- Then streams all 64 coefficients in raster order to the IDCT; index positions never written read out as zero.
- Two banks (ping-pong) so one block fills while the previous block drains.

---
 rtl/jpeg_pkg.sv | 25 ++
 rtl/jpeg_idct_buf_bank.sv | 75 +++++++
 rtl/jpeg_idct_buf.sv | 133 +++++++++++++
 3 files changed

// File: rtl/jpeg_pkg.sv
// Shared types and constants for the JPEG IDCT coefficient buffer.
// Bits [ID_W-1:ID_W-2] of a block id carry the colour component.
package jpeg_pkg;

  localparam int JPEG_BLK_SIZE = 64;
  localparam int JPEG_DATA_W   = 16;
  localparam int JPEG_ID_W     = 32;

  typedef logic signed [JPEG_DATA_W-1:0] coef_t;
  typedef logic [5:0]                    blk_idx_t;

  typedef enum logic [1:0] {
    COMP_Y  = 2'd0,
    COMP_CB = 2'd1,
    COMP_CR = 2'd2
  } comp_e;

  localparam int JPEG_COMP_MSB = JPEG_ID_W - 1;
  localparam int JPEG_COMP_LSB = JPEG_ID_W - 2;

  function automatic comp_e id_comp(input logic [JPEG_ID_W-1:0] id);
    return comp_e'(id[JPEG_COMP_MSB:JPEG_COMP_LSB]);
  endfunction

endpackage

// File: rtl/jpeg_idct_buf_bank.sv
// One ping-pong bank: coefficient RAM with registered read, written mask,
// block id and full flag. Unwritten entries are hidden by the mask.
module jpeg_idct_buf_bank
  import jpeg_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ID_W   = 32
) (
  input  logic              clk_i,
  input  logic              flush_i,
  input  logic              wr_en_i,
  input  logic              wr_first_i,
  input  blk_idx_t          wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ID_W-1:0]   wr_id_i,
  input  logic              wr_eob_i,
  input  logic              rd_en_i,
  input  blk_idx_t          rd_addr_i,
  input  logic              clr_i,
  output logic              full_o,
  output logic [ID_W-1:0]   id_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_mask_o
);

  logic [DATA_W-1:0]        mem [JPEG_BLK_SIZE];
  logic [DATA_W-1:0]        rd_data_q;
  logic [JPEG_BLK_SIZE-1:0] mask_q, mask_d;
  logic                     full_q, full_d;
  logic [ID_W-1:0]          id_q, id_d;
  logic                     rd_mask_q, rd_mask_d;

  always_comb begin
    mask_d    = mask_q;
    full_d    = full_q;
    id_d      = id_q;
    rd_mask_d = rd_mask_q;
    if (clr_i) begin
      mask_d = '0;
      full_d = 1'b0;
    end
    if (wr_en_i) begin
      mask_d[wr_idx_i] = 1'b1;
      if (wr_first_i) id_d = wr_id_i;
      if (wr_eob_i) full_d = 1'b1;
    end
    // Mask is sampled in the same cycle as the RAM read so both line up.
    if (rd_en_i) rd_mask_d = mask_q[rd_addr_i];
  end

  always_ff @(posedge clk_i) begin
    if (flush_i) begin
      mask_q    <= '0;
      full_q    <= 1'b0;
      id_q      <= '0;
      rd_mask_q <= 1'b0;
    end else begin
      mask_q    <= mask_d;
      full_q    <= full_d;
      id_q      <= id_d;
      rd_mask_q <= rd_mask_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem[wr_idx_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem[rd_addr_i];
  end

  assign full_o    = full_q;
  assign id_o      = id_q;
  assign rd_data_o = rd_data_q;
  assign rd_mask_o = rd_mask_q;

endmodule

// File: rtl/jpeg_idct_buf.sv
// Ping-pong coefficient buffer between dezigzag and IDCT: sparse writes by
// natural index, then 64-beat drain. JPEG_IDCT_BUF_TRANSPOSE_EN selects column-major reads.
module jpeg_idct_buf
  import jpeg_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ID_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              img_start_i,
  input  logic              inport_valid_i,
  input  logic [DATA_W-1:0] inport_data_i,
  input  blk_idx_t          inport_idx_i,
  input  logic [ID_W-1:0]   inport_id_i,
  input  logic              inport_eob_i,
  output logic              ready_o,
  output logic              v_o,
  output logic [DATA_W-1:0] outport_data_o,
  output blk_idx_t          outport_idx_o,
  output logic [ID_W-1:0]   outport_id_o,
  output logic              outport_last_o,
  input  logic              yumi_i
);

  logic              flush, accept, issue, drain;
  logic [1:0]        bank_full, bank_rd_mask;
  logic [ID_W-1:0]   bank_id      [2];
  logic [DATA_W-1:0] bank_rd_data [2];

  logic              wr_bank_q, wr_bank_d;
  logic              wr_first_q, wr_first_d;
  logic              rd_bank_q, rd_bank_d;
  logic              rd_done_q, rd_done_d;
  logic              out_valid_q, out_valid_d;
  blk_idx_t          rd_idx_q, rd_idx_d;
  blk_idx_t          out_idx_q, out_idx_d;
  blk_idx_t          rd_addr;
  logic [ID_W-1:0]   out_id_q, out_id_d;

  assign flush   = rst_i | img_start_i;
  assign ready_o = !bank_full[wr_bank_q];
  assign accept  = inport_valid_i & ready_o & !flush;
  // Issue a RAM read whenever the output register is empty or being taken.
  assign issue   = !flush & bank_full[rd_bank_q] & !rd_done_q & (!out_valid_q | yumi_i);
  assign drain   = !flush & yumi_i & outport_last_o;

`ifdef JPEG_IDCT_BUF_TRANSPOSE_EN
  assign rd_addr = {rd_idx_q[2:0], rd_idx_q[5:3]};
`else
  assign rd_addr = rd_idx_q;
`endif

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      localparam logic SEL = 1'(gi);
      jpeg_idct_buf_bank #(.DATA_W(DATA_W), .ID_W(ID_W)) u_bank (
        .clk_i     (clk_i),
        .flush_i   (flush),
        .wr_en_i   (accept & (wr_bank_q == SEL)),
        .wr_first_i(wr_first_q),
        .wr_idx_i  (inport_idx_i),
        .wr_data_i (inport_data_i),
        .wr_id_i   (inport_id_i),
        .wr_eob_i  (inport_eob_i),
        .rd_en_i   (issue & (rd_bank_q == SEL)),
        .rd_addr_i (rd_addr),
        .clr_i     (drain & (rd_bank_q == SEL)),
        .full_o    (bank_full[gi]),
        .id_o      (bank_id[gi]),
        .rd_data_o (bank_rd_data[gi]),
        .rd_mask_o (bank_rd_mask[gi])
      );
    end
  endgenerate

  always_comb begin
    wr_bank_d   = wr_bank_q;
    wr_first_d  = wr_first_q;
    rd_bank_d   = rd_bank_q;
    rd_idx_d    = rd_idx_q;
    rd_done_d   = rd_done_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_id_d    = out_id_q;
    if (accept) begin
      wr_first_d = inport_eob_i;
      if (inport_eob_i) wr_bank_d = ~wr_bank_q;
    end
    if (yumi_i) out_valid_d = 1'b0;
    if (issue) begin
      rd_idx_d    = rd_idx_q + 6'd1;
      if (rd_idx_q == 6'd63) rd_done_d = 1'b1;
      out_valid_d = 1'b1;
      out_idx_d   = rd_addr;
      out_id_d    = bank_id[rd_bank_q];
    end
    if (drain) begin
      rd_bank_d = ~rd_bank_q;
      rd_idx_d  = '0;
      rd_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (flush) begin
      wr_bank_q   <= 1'b0;
      wr_first_q  <= 1'b1;
      rd_bank_q   <= 1'b0;
      rd_idx_q    <= '0;
      rd_done_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_id_q    <= '0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      wr_first_q  <= wr_first_d;
      rd_bank_q   <= rd_bank_d;
      rd_idx_q    <= rd_idx_d;
      rd_done_q   <= rd_done_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_id_q    <= out_id_d;
    end
  end

  assign v_o            = out_valid_q;
  assign outport_idx_o  = out_idx_q;
  assign outport_id_o   = out_id_q;
  assign outport_last_o = out_valid_q & (out_idx_q == 6'd63);
  assign outport_data_o = bank_rd_mask[rd_bank_q] ? bank_rd_data[rd_bank_q] : '0;

endmodule
